// File: rtl/v19_pulse_generator.sv
// v19_pulse_generator
// Synthetic ADC pulse source used as stimulus for the shaping filter.
// Each pulse rises linearly from the baseline in 2^RISE_SHIFT steps, then
// decays exponentially back to the baseline. After the decay a fixed idle
// gap of GAP cycles is enforced before the next request can be accepted.
//
// Optional feature macro: V19_PULSE_GEN_PILEUP_EN
//   defined   - a start request during DECAY adds the new amplitude on top
//               of the current excess (pile-up) and is not counted as missed.
//   undefined - a start request during DECAY is ignored and counted.

module v19_pulse_generator #(
    parameter int DATA_W      = 12,
    parameter int BASELINE    = 100,
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 4,
    parameter int GAP         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] amplitude,
    output logic [DATA_W-1:0] output_data,
    output logic              busy,
    output logic              pulse_done,
    output logic [7:0]        missed_count
);

    localparam int EXC_W    = DATA_W + 1;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int RCNT_W   = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int GCNT_W   = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [RCNT_W-1:0] RISE_LAST = RCNT_W'(RISE_LEN - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP - 1);
    localparam logic [DATA_W-1:0] OUT_MAX   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] BASE_OUT  = DATA_W'(BASELINE);

`ifdef V19_PULSE_GEN_PILEUP_EN
    localparam bit PILEUP = 1'b1;
`else
    localparam bit PILEUP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_DECAY = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_r;
    logic [EXC_W-1:0]    excess_r;
    logic [DATA_W-1:0]   amp_r;
    logic [DATA_W-1:0]   step_r;
    logic [RCNT_W-1:0]   rise_cnt_r;
    logic [GCNT_W-1:0]   gap_cnt_r;
    logic [DATA_W-1:0]   output_data_r;
    logic                busy_r;
    logic                pulse_done_r;
    logic [7:0]          missed_r;

    logic [DATA_W-1:0]   step_new_s;
    logic [EXC_W-1:0]    rise_sum_s;
    logic [EXC_W-1:0]    shr_s;
    logic [EXC_W-1:0]    decr_s;
    logic [EXC_W-1:0]    decay_s;
    logic [EXC_W:0]      pile_sum_s;
    logic [EXC_W-1:0]    pile_s;

    // Output sample for a given excess: baseline plus excess, clamped to full scale.
    function automatic logic [DATA_W-1:0] sat_out(input logic [EXC_W-1:0] e);
        logic [EXC_W:0] sum;
        sum = {1'b0, e} + {{(EXC_W+1-DATA_W){1'b0}}, BASE_OUT};
        if (sum > {{(EXC_W+1-DATA_W){1'b0}}, OUT_MAX}) begin
            return OUT_MAX;
        end else begin
            return sum[DATA_W-1:0];
        end
    endfunction

    // Saturating increment for the missed-request counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] m);
        if (m == 8'hFF) begin
            return m;
        end else begin
            return m + 8'd1;
        end
    endfunction

    // Datapath candidates for the next excess value in each pulse phase.
    always_comb begin
        step_new_s = amplitude >> RISE_SHIFT;
        rise_sum_s = excess_r + {1'b0, step_r};
        shr_s      = excess_r >> DECAY_SHIFT;
        if (shr_s == {EXC_W{1'b0}}) begin
            decr_s = {{(EXC_W-1){1'b0}}, 1'b1};
        end else begin
            decr_s = shr_s;
        end
        decay_s    = excess_r - decr_s;
        pile_sum_s = {1'b0, excess_r} + {2'b00, amplitude};
        if (pile_sum_s[EXC_W]) begin
            pile_s = {EXC_W{1'b1}};
        end else begin
            pile_s = pile_sum_s[EXC_W-1:0];
        end
    end

    // Pulse FSM; output sample, busy and strobe are registered with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            excess_r      <= {EXC_W{1'b0}};
            amp_r         <= {DATA_W{1'b0}};
            step_r        <= {DATA_W{1'b0}};
            rise_cnt_r    <= {RCNT_W{1'b0}};
            gap_cnt_r     <= {GCNT_W{1'b0}};
            output_data_r <= BASE_OUT;
            busy_r        <= 1'b0;
            pulse_done_r  <= 1'b0;
            missed_r      <= 8'd0;
        end else begin
            pulse_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        amp_r  <= amplitude;
                        step_r <= step_new_s;
                        busy_r <= 1'b1;
                        if (RISE_SHIFT == 0) begin
                            // Single-step rise: jump straight to the peak.
                            excess_r      <= {1'b0, amplitude};
                            output_data_r <= sat_out({1'b0, amplitude});
                            rise_cnt_r    <= {RCNT_W{1'b0}};
                            state_r       <= ST_DECAY;
                        end else begin
                            excess_r      <= {1'b0, step_new_s};
                            output_data_r <= sat_out({1'b0, step_new_s});
                            rise_cnt_r    <= RCNT_W'(1);
                            state_r       <= ST_RISE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RISE: begin
                    if (start) begin
                        missed_r <= sat_inc(missed_r);
                    end
                    if (rise_cnt_r == RISE_LAST) begin
                        // Land exactly on the amplitude, hiding the step truncation.
                        excess_r      <= {1'b0, amp_r};
                        output_data_r <= sat_out({1'b0, amp_r});
                        state_r       <= ST_DECAY;
                    end else begin
                        excess_r      <= rise_sum_s;
                        output_data_r <= sat_out(rise_sum_s);
                        rise_cnt_r    <= rise_cnt_r + RCNT_W'(1);
                    end
                end
                ST_DECAY: begin
                    if (PILEUP && start) begin
                        excess_r      <= pile_s;
                        output_data_r <= sat_out(pile_s);
                    end else begin
                        if (start) begin
                            missed_r <= sat_inc(missed_r);
                        end
                        if (excess_r == {EXC_W{1'b0}}) begin
                            state_r      <= ST_GAP;
                            pulse_done_r <= 1'b1;
                            gap_cnt_r    <= {GCNT_W{1'b0}};
                        end else begin
                            excess_r      <= decay_s;
                            output_data_r <= sat_out(decay_s);
                        end
                    end
                end
                ST_GAP: begin
                    if (start) begin
                        missed_r <= sat_inc(missed_r);
                    end
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        gap_cnt_r <= {GCNT_W{1'b0}};
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GCNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    excess_r      <= {EXC_W{1'b0}};
                    output_data_r <= BASE_OUT;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign output_data  = output_data_r;
    assign busy         = busy_r;
    assign pulse_done   = pulse_done_r;
    assign missed_count = missed_r;

endmodule

// File: tb/tb_v19_pulse_generator.sv
// Self-checking bench for v19_pulse_generator (default parameters).
// Expected per-cycle samples are queued when a pulse is requested and popped
// as the DUT produces them; pile-up expectations follow V19_PULSE_GEN_PILEUP_EN.

module tb_v19_pulse_generator;

    localparam int DW   = 12;
    localparam int BASE = 100;
    localparam int RS   = 2;
    localparam int DS   = 4;
    localparam int GP   = 16;
    localparam int OMAX = 4095;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] amplitude;
    logic [DW-1:0] output_data;
    logic          busy;
    logic          pulse_done;
    logic [7:0]    missed_count;

    typedef struct {
        int out;
        int bsy;
        int dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk;
    int   n_bad;
    int   lit19[6];

    v19_pulse_generator dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .amplitude    (amplitude),
        .output_data  (output_data),
        .busy         (busy),
        .pulse_done   (pulse_done),
        .missed_count (missed_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > OMAX) ? OMAX : v;
    endfunction

    task automatic push(input int o, input int b, input int d);
        exp_t e;
        e.out = o;
        e.bsy = b;
        e.dn  = d;
        sb_q.push_back(e);
    endtask

    // Expected samples from the first one after the accepting edge until idle.
    task automatic push_pulse(input int a);
        int e;
        int d;
        int step;
        step = a >> RS;
        for (int i = 1; i < (1 << RS); i++) push(sat(BASE + step * i), 1, 0);
        e = a;
        push(sat(BASE + e), 1, 0);
        while (e > 0) begin
            d = e >> DS;
            if (d < 1) d = 1;
            e = e - d;
            push(sat(BASE + e), 1, 0);
        end
        push(BASE, 1, 1);
        for (int i = 1; i < GP; i++) push(BASE, 1, 0);
        push(BASE, 0, 0);
    endtask

    task automatic drain(input int lit);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out", int'(output_data), e.out);
            chk("busy", int'(busy), e.bsy);
            chk("done", int'(pulse_done), e.dn);
            if (lit != 0 && idx < 6) chk("req19_seq", int'(output_data), lit19[idx]);
            idx++;
            if (sb_q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic run_pulse(input int a, input int lit);
        @(negedge clk);
        amplitude = DW'(a);
        start     = 1'b1;
        push_pulse(a);
        @(negedge clk);
        start = 1'b0;
        drain(lit);
    endtask

    initial begin
        int seen;
        int run;
        int expm;
        n_chk = 0;
        n_bad = 0;
        lit19 = '{350, 600, 850, 1100, 1038, 980};
        reset     = 1'b0;
        start     = 1'b0;
        amplitude = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", int'(output_data), BASE);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(pulse_done), 0);
        chk("rst_missed", int'(missed_count), 0);
        reset = 1'b1;

        // Nominal pulse, full-scale clamp, zero amplitude
        run_pulse(1000, 1);
        run_pulse(4095, 0);
        run_pulse(0, 0);
        run_pulse(37, 0);
        chk("missed_after_singles", int'(missed_count), 0);

        // Second request mid-decay at excess 880
        @(negedge clk);
        amplitude = 12'd1000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pile_pre", int'(output_data), 980);
        amplitude = 12'd500;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef V19_PULSE_GEN_PILEUP_EN
        chk("pile_out", int'(output_data), 1480);
        expm = 0;
`else
        chk("pile_out", int'(output_data), 925);
        expm = 1;
`endif
        seen = 0;
        for (int i = 0; i < 3000 && seen == 0; i++) begin
            @(negedge clk);
            if (pulse_done) seen = 1;
        end
        chk("pile_done_seen", seen, 1);
        run = 0;
        while (busy && run < 40) begin
            run++;
            @(negedge clk);
        end
        chk("pile_gap_len", run, GP);
        chk("pile_missed", int'(missed_count), expm);

        // Reset during RISE aborts the pulse
        @(negedge clk);
        amplitude = 12'd1000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rise_pre", int'(output_data), 600);
        reset = 1'b0;
        #1;
        chk("abort_out", int'(output_data), BASE);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(pulse_done), 0);
        chk("abort_missed", int'(missed_count), 0);
        @(negedge clk);
        reset = 1'b1;
        run_pulse(1000, 1);

`ifndef V19_PULSE_GEN_PILEUP_EN
        // Start held high: back-to-back pulses, saturating missed count
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        amplitude = '0;
        start     = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            run = 0;
            @(negedge clk);
            while (busy && run < 100) begin
                run++;
                @(negedge clk);
            end
            chk("held_busy_run", run, 4 + GP);
            expm = (k * (3 + 1 + GP) > 255) ? 255 : k * (3 + 1 + GP);
            chk("held_missed", int'(missed_count), expm);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_idle", int'(busy), 0);
        chk("held_sat", int'(missed_count), 255);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/v19_pulse_generator.md
V19_PULSE_GENERATOR -- requirements
Module: v19_pulse_generator

Interface
REQ-001 SHALL have parameters, one per line:
  DATA_W, 12, sample width of output_data (ADC width).
  BASELINE, 100, idle output level.
  RISE_SHIFT, 2, rise length = 2^RISE_SHIFT cycles.
  DECAY_SHIFT, 4, exponential decay constant (per cycle excess -= excess>>DECAY_SHIFT).
  GAP, 16, minimum idle cycles after a pulse ends (>=1).
REQ-002 SHALL have ports, one per line:
  clk  input  1  single clock, all logic on rising edge.
  reset  input  1  asynchronous, active-low reset.
  start  input  1  pulse request, sampled each rising edge.
  amplitude  input  DATA_W  pulse height above baseline, latched on acceptance.
  output_data  output  DATA_W  registered synthetic ADC sample.
  busy  output  1  high whenever FSM is not IDLE.
  pulse_done  output  1  one-cycle strobe at end of decay.
  missed_count  output  8  saturating count of ignored start requests.

Function
REQ-003 SHALL generate exponential-tail pulses on a constant baseline, as stimulus for the shaping filter.
REQ-004 SHALL hold internal excess register (DATA_W+1 bits, unsigned); output_data = min(BASELINE + excess, 2^DATA_W-1), registered.
REQ-005 SHALL implement FSM states IDLE, RISE, DECAY, GAP; busy = (state != IDLE).
REQ-006 IDLE: on edge with start=1 -> latch amplitude A, step = A>>RISE_SHIFT, excess <= step, rise counter <= 1, go RISE; output changes on the accepting edge's next sample.
REQ-007 RISE: each edge excess += step, counter++; on the edge counter reaches 2^RISE_SHIFT-1, excess <= A exactly, go DECAY.
REQ-008 RISE_SHIFT=0: acceptance loads excess <= A and goes directly to DECAY.
REQ-009 DECAY: each edge excess <= excess - max(excess>>DECAY_SHIFT, 1); when excess is 0 on an edge, go GAP, pulse_done=1 for that cycle, gap counter <= 0.
REQ-010 A=0: accepted; excess stays 0; DECAY exits on first edge.
REQ-011 GAP: counts GAP cycles with excess 0, then IDLE; start in IDLE on the cycle after GAP is accepted.
REQ-012 start while not accepted (per REQ-013/Configuration) -> ignored, missed_count += 1, saturating at 255.
REQ-013 start in RISE or GAP SHALL always be ignored and counted.

Reset
REQ-014 reset low SHALL immediately force: state IDLE, excess 0, counters 0, output_data = BASELINE, busy 0, pulse_done 0, missed_count 0, latched A 0.
REQ-015 reset asserted mid-pulse SHALL abort the pulse; no pulse_done issued; first start after release accepted normally.

Configuration
REQ-016 Macro V19_PULSE_GEN_PILEUP_EN SHALL select pile-up support.
REQ-017 Defined: start in DECAY accepted -> excess <= min(excess + amplitude, 2^(DATA_W+1)-1), stays in DECAY, missed_count unchanged.
REQ-018 Undefined: start in DECAY ignored and counted per REQ-012.

Verification
REQ-019 Defaults, A=1000, single start -> output_data 350,600,850,1100 then 1038,980 (excess 1000->938->880), pulse_done once, busy low 16 cycles after done.
REQ-020 DATA_W=12, A=4095 -> output_data clamps at 4095 during peak, then decays; no wrap.
REQ-021 A=0 -> output stays 100, pulse_done after RISE, IDLE after GAP.
REQ-022 start held high continuously -> back-to-back pulses separated by exactly GAP idle cycles; missed_count increments each ignored cycle, saturates at 255.
REQ-023 Macro defined, second start A=500 mid-DECAY at excess 880 -> excess 1380, output 1480; macro undefined -> ignored, missed_count 1.
REQ-024 reset low during RISE -> output 100, busy 0 immediately; next start produces full REQ-019 sequence.
